// File: rtl/ifetch_bp.sv
// rtl/ifetch_bp.sv - instruction fetch stage with 2-bit saturating-counter branch predictor
module ifetch_bp #(
  parameter int              PC_W       = 16,
  parameter int              BHT_DEPTH  = 16,
  parameter int              BHT_IDX_W  = $clog2(BHT_DEPTH),
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter bit              PREDICT_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            stall_pc_i,
  input  logic            jr_i,
  input  logic [PC_W-1:0] address_jr_i,
  input  logic            branch_resolve_i,
  input  logic            branch_taken_i,
  input  logic [15:0]     instr_i,
  output logic            pred_taken_o,
  output logic            flush_o,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pcplus1_o,
  output logic [PC_W-1:0] epc_o
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0]      pc;
  logic [PC_W-1:0]      pc_plus1;
  logic [PC_W-1:0]      target;
  logic [PC_W-1:0]      imm;
  logic [PC_W-1:0]      next_pc;
  logic [BHT_IDX_W-1:0] idx;
  logic [4:0]           opcode;
  logic                 is_b;
  logic                 is_cond;
  logic                 pred_taken;
  logic                 mispredict;

  logic [PC_W-1:0]      pc_lock;
  logic [PC_W-1:0]      fallthru_lock;
  logic [PC_W-1:0]      target_lock;
  logic                 pred_lock;
  logic [BHT_IDX_W-1:0] idx_lock;
  logic                 cond_lock;

  logic [1:0]           ctr [BHT_DEPTH];

  // Pre-decode: B carries an 11-bit offset, the conditional forms an 8-bit one
  always_comb begin
    opcode  = instr_i[15:11];
    is_b    = (opcode == 5'b00010);
    is_cond = (opcode == 5'b00100) || (opcode == 5'b00101) ||
              ((opcode == 5'b01100) && (instr_i[10:9] == 2'b00));
    if (is_b) begin
      imm = {{(PC_W-11){instr_i[10]}}, instr_i[10:0]};
    end else begin
      imm = {{(PC_W-8){instr_i[7]}}, instr_i[7:0]};
    end
  end

  assign idx        = pc[BHT_IDX_W-1:0];
  assign pc_plus1   = pc + PC_ONE;
  assign target     = pc_plus1 + imm;
  assign pred_taken = is_b | (is_cond & PREDICT_EN & ctr[idx][1]);
  assign mispredict = branch_resolve_i & (branch_taken_i != pred_lock);

  always_comb begin
    next_pc = pc_plus1;
    if (jr_i) begin
      next_pc = address_jr_i;
    end else if (mispredict) begin
      next_pc = branch_taken_i ? target_lock : fallthru_lock;
    end else if (pred_taken) begin
      next_pc = target;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc            <= RESET_PC;
      pc_lock       <= '0;
      fallthru_lock <= '0;
      target_lock   <= '0;
      pred_lock     <= 1'b0;
      idx_lock      <= '0;
      cond_lock     <= 1'b0;
    end else if (!stall_pc_i) begin
      pc            <= next_pc;
      pc_lock       <= pc;
      fallthru_lock <= pc_plus1;
      target_lock   <= target;
      pred_lock     <= pred_taken;
      idx_lock      <= idx;
      cond_lock     <= is_cond;
    end
  end

  // Training uses the locked index; a same-cycle lookup sees the pre-update value
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (!stall_pc_i && branch_resolve_i && cond_lock) begin
      if (branch_taken_i && (ctr[idx_lock] != 2'b11)) begin
        ctr[idx_lock] <= ctr[idx_lock] + 2'b01;
      end else if (!branch_taken_i && (ctr[idx_lock] != 2'b00)) begin
        ctr[idx_lock] <= ctr[idx_lock] - 2'b01;
      end
    end
  end

  assign pred_taken_o = pred_taken;
  assign flush_o      = jr_i | mispredict;
  assign pc_o         = pc;
  assign pcplus1_o    = pc_plus1;
  assign epc_o        = (branch_resolve_i | jr_i) ? pc_lock : pc;

endmodule

// File: tb/tb_ifetch_bp.sv
// tb/tb_ifetch_bp.sv - directed self-checking bench for ifetch_bp
module tb_ifetch_bp;

  localparam logic [15:0] NOP    = 16'h0800;
  localparam logic [15:0] B_M2   = 16'h17FE;
  localparam logic [15:0] BEQZ_3 = 16'h2003;
  localparam logic [15:0] BNEZ_2 = 16'h2802;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall_pc_i;
  logic        jr_i;
  logic [15:0] address_jr_i;
  logic        branch_resolve_i;
  logic        branch_taken_i;
  logic [15:0] instr_i;
  logic        pred_taken_o;
  logic        flush_o;
  logic [15:0] pc_o;
  logic [15:0] pcplus1_o;
  logic [15:0] epc_o;

  int checks = 0;
  int errors = 0;

  ifetch_bp #(
    .PC_W      (16),
    .BHT_DEPTH (16),
    .RESET_PC  (16'h0000),
    .PREDICT_EN(1'b1)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .stall_pc_i      (stall_pc_i),
    .jr_i            (jr_i),
    .address_jr_i    (address_jr_i),
    .branch_resolve_i(branch_resolve_i),
    .branch_taken_i  (branch_taken_i),
    .instr_i         (instr_i),
    .pred_taken_o    (pred_taken_o),
    .flush_o         (flush_o),
    .pc_o            (pc_o),
    .pcplus1_o       (pcplus1_o),
    .epc_o           (epc_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic jump(input logic [15:0] addr);
    instr_i      = NOP;
    jr_i         = 1'b1;
    address_jr_i = addr;
    step();
    jr_i         = 1'b0;
  endtask

  logic       tkn_tab  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       pred_tab [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST              = 1'b0;
    stall_pc_i       = 1'b0;
    jr_i             = 1'b0;
    address_jr_i     = '0;
    branch_resolve_i = 1'b0;
    branch_taken_i   = 1'b0;
    instr_i          = NOP;
    #3;
    check("reset_pc", pc_o, 16'h0000);
    check("reset_pred", pred_taken_o, 1'b0);
    check("reset_flush", flush_o, 1'b0);
    check("reset_pcplus1", pcplus1_o, 16'h0001);
    step();
    RST = 1'b1;
    settle();
    check("post_reset_pc", pc_o, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", pc_o, 16'(i));
      check("seq_pred", pred_taken_o, 1'b0);
    end

    // Unconditional backward branch
    jump(16'h0010);
    check("jr_pc", pc_o, 16'h0010);
    instr_i = B_M2;
    settle();
    check("b_pred", pred_taken_o, 1'b1);
    check("b_flush", flush_o, 1'b0);
    step();
    check("b_target", pc_o, 16'h000F);

    // BEQZ mispredict, train, refetch
    jump(16'h0004);
    instr_i = BEQZ_3;
    settle();
    check("beqz_pred0", pred_taken_o, 1'b0);
    step();
    check("beqz_fall_pc", pc_o, 16'h0005);
    instr_i          = NOP;
    branch_resolve_i = 1'b1;
    branch_taken_i   = 1'b1;
    settle();
    check("mispred_flush", flush_o, 1'b1);
    check("mispred_epc", epc_o, 16'h0004);
    step();
    branch_resolve_i = 1'b0;
    check("mispred_pc", pc_o, 16'h0008);
    jump(16'h0004);
    instr_i = BEQZ_3;
    settle();
    check("beqz_pred1", pred_taken_o, 1'b1);
    step();
    check("beqz_taken_pc", pc_o, 16'h0008);

    // Counter saturation at BNEZ (idx 0): 01 -> 10 -> 11 -> 11.. -> 10 -> 01
    jump(16'h0020);
    for (int i = 0; i < 7; i++) begin
      instr_i = BNEZ_2;
      settle();
      check($sformatf("sat_pred%0d", i), pred_taken_o, pred_tab[i]);
      step();
      instr_i          = NOP;
      branch_resolve_i = 1'b1;
      branch_taken_i   = tkn_tab[i];
      jr_i             = 1'b1;
      address_jr_i     = 16'h0020;
      step();
      branch_resolve_i = 1'b0;
      jr_i             = 1'b0;
      check($sformatf("sat_pc%0d", i), pc_o, 16'h0020);
    end
    instr_i = BNEZ_2;
    settle();
    check("sat_final_pred", pred_taken_o, 1'b0);

    // jr + mispredict while stalled
    step();
    check("pre_stall_pc", pc_o, 16'h0021);
    instr_i          = NOP;
    stall_pc_i       = 1'b1;
    jr_i             = 1'b1;
    address_jr_i     = 16'h1234;
    branch_resolve_i = 1'b1;
    branch_taken_i   = 1'b1;
    settle();
    check("stall_flush", flush_o, 1'b1);
    check("stall_epc", epc_o, 16'h0020);
    step();
    check("stall_pc1", pc_o, 16'h0021);
    check("stall_flush1", flush_o, 1'b1);
    step();
    check("stall_pc2", pc_o, 16'h0021);
    stall_pc_i = 1'b0;
    step();
    jr_i             = 1'b0;
    branch_resolve_i = 1'b0;
    check("jr_wins_pc", pc_o, 16'h1234);

    // PC wrap
    jump(16'hFFFF);
    check("wrap_pc", pc_o, 16'hFFFF);
    check("wrap_pcplus1", pcplus1_o, 16'h0000);
    step();
    check("wrap_next_pc", pc_o, 16'h0000);

    // Reset mid-stall clears pc and counters (ctr[0] is 10 here)
    jump(16'h0020);
    instr_i = BNEZ_2;
    settle();
    check("pre_rst_pred", pred_taken_o, 1'b1);
    instr_i    = NOP;
    stall_pc_i = 1'b1;
    step();
    check("pre_rst_pc", pc_o, 16'h0020);
    #2;
    RST = 1'b0;
    #1;
    check("async_rst_pc", pc_o, 16'h0000);
    #1;
    RST        = 1'b1;
    stall_pc_i = 1'b0;
    instr_i    = BNEZ_2;
    settle();
    check("rst_ctr0_pred", pred_taken_o, 1'b0);
    jump(16'h0004);
    instr_i = BEQZ_3;
    settle();
    check("rst_ctr4_pred", pred_taken_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
